rstatus_unit: RTL and testbench
===============================

# rstatus_unit

Registered, parametrised successor to the combinational overflow decoder. It sits between execute and writeback. It classifies overflow and exception events from ALU instructions (add, addi, sub) and from the multi-cycle mult/div unit, and queues the resulting status codes in order. It presents them one at a time to the writeback port that owns `$rstatus`. It also tracks a sticky cumulative status bitmap and throttles execute before the queue can overflow.

## Interface
Parameters:
- `WIDTH`, 32: width of `status_code` and `sticky_status`; must be ≥ 8.
- `QDEPTH`, 4: status queue depth; must be ≥ 2.
- `OP_W`, 5: opcode and ALU-op field width.

Ports:
- `clock`  in  1: single clock, rising-edge.
- `reset`  in  1: synchronous, active-high.
- `x_valid`  in  1: instruction in X stage is valid.
- `stall`  in  1: X stage held this cycle; no classification.
- `flush`  in  1: discard this cycle's X event and abort any in-flight mult/div.
- `x_op`  in  OP_W: opcode in X.
- `x_aluop`  in  OP_W: ALU-op field in X.
- `alu_ovf`  in  1: ALU overflow flag for the X instruction.
- `md_ready`  in  1: mult/div result complete.
- `md_exception`  in  1: mult/div exception; qualified by `md_ready`.
- `wb_grant`  in  1: writeback accepts the head status this cycle.
- `sticky_clear`  in  1: clear `sticky_status`.
- `status_valid`  out  1: queue non-empty.
- `status_code`  out  WIDTH: head code, zero-extended; 0 when empty.
- `stall_req`  out  1: free slots < 2.
- `sticky_status`  out  WIDTH: bit k set once code k has been popped.
- `proto_err`  out  1: sticky; a mult/div was issued while one was already busy.

## Operation
- An X event is qualified by `x_valid & !stall & !flush`.
- R-type means `x_op`=00000.
- Status codes:
  - add (aluop 00000) → 1
  - addi (op 00101) → 2
  - sub (aluop 00001) → 3
  - mult (aluop 00110) → 4
  - div (aluop 00111) → 5
- Unlike the prior decoder, add/addi/sub push a code only when `alu_ovf`=1.
- mult/div FSM has two states, IDLE and MD_BUSY, and records the kind (mult or div).
  - IDLE → MD_BUSY on a qualified mult/div event; the kind is latched.
  - MD_BUSY → IDLE on `md_ready`. If `md_exception`, push code 4 or 5 according to the latched kind.
  - A qualified mult/div event while in MD_BUSY is ignored and sets `proto_err`.
  - `flush` in MD_BUSY → IDLE with no push, even if `md_ready` is asserted in the same cycle.
  - `md_ready` while in IDLE is ignored.
- Queue ordering:
  - Up to two pushes per cycle.
  - When an mult/div push and an ALU push occur in the same cycle, the mult/div code is enqueued first, because it belongs to the older instruction.
- A pop occurs on `status_valid & wb_grant`. Push and pop in the same cycle are legal, including when the queue is full.
- `stall_req` = (QDEPTH − count) < 2, computed from registered count. Upstream must honour it, so the queue never overflows. A push into a full queue is a protocol violation; the queue state must stay unchanged (assertion).
- Sticky bitmap: on a pop, set bit `status_code`. On `sticky_clear`, zero the bitmap. If clear and set coincide, the set wins (clear first, then set). Bits 0 and 6 and above are always 0.
- Reset values: queue empty, `status_valid`=0, `status_code`=0, `stall_req`=0, `sticky_status`=0, `proto_err`=0, FSM IDLE.

## Timing
- An ALU event at cycle t → `status_valid`/`status_code` at t+1, if the queue was empty.
- `md_ready`+`md_exception` at t → visible at t+1.
- A pop at t → the next entry or empty at t+1. `sticky_status` updates at t+1.
- `stall_req` reflects occupancy after the edge. It may be asserted one cycle pessimistically when a pop coincides.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-operation discards the queue, in-flight mult/div and sticky state on the next edge.

## Structure
- Package `rstatus_pkg`:
  - opcode constants (R-type, addi)
  - ALU-op constants (add, sub, mult, div)
  - status code constants 1–5
  - FSM state enum
  - mult/div kind type
- Sub-module `status_fifo`: 2-write/1-read circular buffer, depth QDEPTH, with count output. It holds the pointer wrap logic.
- Top level contains the classifier, the FSM, the sticky register and the stall logic.

## Test plan
- Reset, then add with `alu_ovf`=1 at t → `status_code`=1 at t+1; add with `alu_ovf`=0 → `status_valid` stays 0.
- Div issued; `md_ready`+`md_exception` 6 cycles later while an addi overflows in the same cycle → queue holds 5 then 2; pops in that order with `wb_grant`.
- QDEPTH=4, `wb_grant`=0, three sub overflows → `stall_req` rises after the third push (count 3). Then push and pop in the same cycle at count 3 → count stays 3.
- Mult in flight, `flush` together with `md_ready`+`md_exception` → no push, FSM IDLE. A second mult issued while busy → `proto_err`=1.
- Pop codes 1 and 4, then `sticky_clear` asserted in the same cycle as a pop of code 3 → `sticky_status`=0x8 after 0x12.
- Reset asserted with 3 entries queued → next cycle `status_valid`=0, `status_code`=0, `sticky_status`=0.

Source files
------------

// File: rtl/rstatus_pkg.sv
// Shared constants and types for the registered status unit.
package rstatus_pkg;

  // Width of a stored status code (codes 1..5 fit in 3 bits).
  localparam int unsigned CodeW = 3;

  // Opcode field values.
  localparam logic [4:0] OpRtype = 5'b00000;
  localparam logic [4:0] OpAddi  = 5'b00101;

  // ALU-op field values for R-type instructions.
  localparam logic [4:0] AluAdd  = 5'b00000;
  localparam logic [4:0] AluSub  = 5'b00001;
  localparam logic [4:0] AluMult = 5'b00110;
  localparam logic [4:0] AluDiv  = 5'b00111;

  // Status codes as seen on the writeback port.
  localparam logic [CodeW-1:0] CodeAdd  = 3'd1;
  localparam logic [CodeW-1:0] CodeAddi = 3'd2;
  localparam logic [CodeW-1:0] CodeSub  = 3'd3;
  localparam logic [CodeW-1:0] CodeMult = 3'd4;
  localparam logic [CodeW-1:0] CodeDiv  = 3'd5;

  typedef enum logic {StIdle, StMdBusy} md_state_e;
  typedef enum logic {MdMult, MdDiv} md_kind_e;

endpackage

// File: rtl/status_fifo.sv
// Two-write/one-read circular status queue with occupancy count.
module status_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned DataW = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr0_en_i,
  input  logic [DataW-1:0]           wr0_data_i,
  input  logic                       wr1_en_i,
  input  logic [DataW-1:0]           wr1_data_i,
  input  logic                       rd_en_i,
  output logic [DataW-1:0]           rd_data_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic            pop;
  logic [CntW:0]   occ_next;
  logic            overflow;
  logic            first_en;
  logic            second_en;
  logic [DataW-1:0] first_data;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state: pop the head, then append up to two entries (port 0 first).
  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    pop        = rd_en_i && (count_q != '0);
    occ_next   = {1'b0, count_q} + (CntW+1)'(wr0_en_i) + (CntW+1)'(wr1_en_i)
                 - (CntW+1)'(pop);
    overflow   = occ_next > (CntW+1)'(Depth);
    first_en   = wr0_en_i | wr1_en_i;
    second_en  = wr0_en_i & wr1_en_i;
    first_data = wr0_en_i ? wr0_data_i : wr1_data_i;
    // An overflowing push leaves the whole queue untouched.
    if (!overflow) begin
      if (pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      if (first_en) begin
        mem_d[wptr_d] = first_data;
        wptr_d        = ptr_inc(wptr_d);
      end
      if (second_en) begin
        mem_d[wptr_d] = wr1_data_i;
        wptr_d        = ptr_inc(wptr_d);
      end
      count_d = occ_next[CntW-1:0];
    end
  end

  // Queue state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign rd_data_o = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign count_o   = count_q;

  no_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i) !overflow)
    else $error("status_fifo: push into full queue");

endmodule

// File: rtl/rstatus_unit.sv
// Classifies ALU and mult/div status events, queues them in order and tracks sticky status.
module rstatus_unit
  import rstatus_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned OP_W   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [OP_W-1:0]  x_op,
  input  logic [OP_W-1:0]  x_aluop,
  input  logic             alu_ovf,
  input  logic             md_ready,
  input  logic             md_exception,
  input  logic             wb_grant,
  input  logic             sticky_clear,
  output logic             status_valid,
  output logic [WIDTH-1:0] status_code,
  output logic             stall_req,
  output logic [WIDTH-1:0] sticky_status,
  output logic             proto_err
);

  localparam int unsigned CntW = $clog2(QDEPTH+1);
  localparam int unsigned StW  = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  md_kind_e         kind_q, kind_d;
  logic             proto_err_q, proto_err_d;
  logic [WIDTH-1:0] sticky_q, sticky_d;

  logic             x_event;
  logic             alu_push;
  logic [CodeW-1:0] alu_code;
  logic             md_issue;
  md_kind_e         md_issue_kind;
  logic             md_push;
  logic [CodeW-1:0] md_code;
  logic             pop;
  logic [CodeW-1:0] head_code;
  logic [CntW-1:0]  q_count;

  // Classify the X-stage instruction into an ALU push and/or a mult/div issue.
  always_comb begin
    x_event       = x_valid & ~stall & ~flush;
    alu_push      = 1'b0;
    alu_code      = '0;
    md_issue      = 1'b0;
    md_issue_kind = MdMult;
    if (x_event) begin
      if (x_op == OP_W'(OpRtype)) begin
        case (x_aluop)
          OP_W'(AluAdd): begin
            alu_push = alu_ovf;
            alu_code = CodeAdd;
          end
          OP_W'(AluSub): begin
            alu_push = alu_ovf;
            alu_code = CodeSub;
          end
          OP_W'(AluMult): begin
            md_issue      = 1'b1;
            md_issue_kind = MdMult;
          end
          OP_W'(AluDiv): begin
            md_issue      = 1'b1;
            md_issue_kind = MdDiv;
          end
          default: ;
        endcase
      end else if (x_op == OP_W'(OpAddi)) begin
        alu_push = alu_ovf;
        alu_code = CodeAddi;
      end
    end
  end

  // Mult/div tracker: busy until completion or flush; issue while busy is a protocol error.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    proto_err_d = proto_err_q;
    md_push     = 1'b0;
    md_code     = (kind_q == MdDiv) ? CodeDiv : CodeMult;
    unique case (state_q)
      StIdle: begin
        if (md_issue) begin
          state_d = StMdBusy;
          kind_d  = md_issue_kind;
        end
      end
      StMdBusy: begin
        if (md_issue) begin
          proto_err_d = 1'b1;
        end
        // Flush wins over a same-cycle completion.
        if (flush) begin
          state_d = StIdle;
        end else if (md_ready) begin
          state_d = StIdle;
          md_push = md_exception;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Mult/div result belongs to the older instruction, so it takes write port 0.
  status_fifo #(
    .Depth (QDEPTH),
    .DataW (CodeW)
  ) u_fifo (
    .clk_i      (clock),
    .rst_i      (reset),
    .wr0_en_i   (md_push),
    .wr0_data_i (md_code),
    .wr1_en_i   (alu_push),
    .wr1_data_i (alu_code),
    .rd_en_i    (pop),
    .rd_data_o  (head_code),
    .count_o    (q_count)
  );

  assign pop = status_valid & wb_grant;

  // Sticky bitmap: clear applies first so a same-cycle pop still sets its bit.
  always_comb begin
    sticky_d = sticky_clear ? '0 : sticky_q;
    if (pop) begin
      sticky_d[StW'(head_code)] = 1'b1;
    end
  end

  // Control and sticky state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      kind_q      <= MdMult;
      proto_err_q <= 1'b0;
      sticky_q    <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      proto_err_q <= proto_err_d;
      sticky_q    <= sticky_d;
    end
  end

  assign status_valid  = (q_count != '0);
  assign status_code   = WIDTH'(head_code);
  // Fewer than two free slots, from registered count.
  assign stall_req     = ({1'b0, q_count} + (CntW+1)'(2)) > (CntW+1)'(QDEPTH);
  assign sticky_status = sticky_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_rstatus_unit.sv
// Directed bench for rstatus_unit with a queue-based reference model.
module tb_rstatus_unit;

  logic        clock;
  logic        reset;
  logic        x_valid;
  logic        stall;
  logic        flush;
  logic [4:0]  x_op;
  logic [4:0]  x_aluop;
  logic        alu_ovf;
  logic        md_ready;
  logic        md_exception;
  logic        wb_grant;
  logic        sticky_clear;
  logic        status_valid;
  logic [31:0] status_code;
  logic        stall_req;
  logic [31:0] sticky_status;
  logic        proto_err;

  int tests = 0;
  int fails = 0;

  rstatus_unit #(
    .WIDTH  (32),
    .QDEPTH (4),
    .OP_W   (5)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .x_valid       (x_valid),
    .stall         (stall),
    .flush         (flush),
    .x_op          (x_op),
    .x_aluop       (x_aluop),
    .alu_ovf       (alu_ovf),
    .md_ready      (md_ready),
    .md_exception  (md_exception),
    .wb_grant      (wb_grant),
    .sticky_clear  (sticky_clear),
    .status_valid  (status_valid),
    .status_code   (status_code),
    .stall_req     (stall_req),
    .sticky_status (sticky_status),
    .proto_err     (proto_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of codes, sticky word, busy/kind for mult/div.
  int          mq[$];
  logic [31:0] m_sticky;
  bit          m_proto;
  bit          m_busy;
  int          m_kind;
  bit          started = 0;

  always @(posedge clock) begin
    int md_c;
    int alu_c;
    int pc;
    bit qual;
    bit rt;
    bit nb;
    if (reset) begin
      mq.delete();
      m_sticky = 0;
      m_proto  = 0;
      m_busy   = 0;
      m_kind   = 0;
      started  = 1;
    end else begin
      md_c  = 0;
      alu_c = 0;
      qual  = x_valid && !stall && !flush;
      rt    = (x_op == 5'd0);
      if (qual && rt && alu_ovf && x_aluop == 5'd0) alu_c = 1;
      if (qual && rt && alu_ovf && x_aluop == 5'd1) alu_c = 3;
      if (qual && x_op == 5'd5 && alu_ovf) alu_c = 2;
      nb = m_busy;
      if (m_busy) begin
        if (flush) nb = 0;
        else if (md_ready) begin
          nb = 0;
          if (md_exception) md_c = m_kind;
        end
      end
      if (qual && rt && (x_aluop == 5'd6 || x_aluop == 5'd7)) begin
        if (m_busy) m_proto = 1;
        else begin
          nb     = 1;
          m_kind = (x_aluop == 5'd6) ? 4 : 5;
        end
      end
      m_busy = nb;
      if (sticky_clear) m_sticky = 0;
      if (mq.size() > 0 && wb_grant) begin
        pc = mq.pop_front();
        m_sticky[pc] = 1'b1;
      end
      if (md_c != 0) mq.push_back(md_c);
      if (alu_c != 0) mq.push_back(alu_c);
      if (mq.size() > 4) begin
        tests++;
        fails++;
        $display("FAIL model_overflow: got %0d entries, expected at most 4", mq.size());
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clock) begin
    if (started) begin
      chk("cmp_valid", 32'(status_valid), 32'(mq.size() > 0));
      chk("cmp_code", status_code, (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
      chk("cmp_stall", 32'(stall_req), 32'((4 - mq.size()) < 2));
      chk("cmp_sticky", sticky_status, m_sticky);
      chk("cmp_proto", 32'(proto_err), 32'(m_proto));
    end
  end

  task automatic idle();
    x_valid      = 0;
    stall        = 0;
    flush        = 0;
    x_op         = 0;
    x_aluop      = 0;
    alu_ovf      = 0;
    md_ready     = 0;
    md_exception = 0;
    wb_grant     = 0;
    sticky_clear = 0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Set up an X-stage instruction for the next edge.
  task automatic xin(input logic [4:0] op, input logic [4:0] aluop, input logic ovf);
    x_valid = 1;
    x_op    = op;
    x_aluop = aluop;
    alu_ovf = ovf;
  endtask

  initial begin
    idle();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    chk("rst_valid", 32'(status_valid), 32'd0);
    chk("rst_code", status_code, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_sticky", sticky_status, 32'd0);
    chk("rst_proto", 32'(proto_err), 32'd0);

    // add overflow shows next cycle; add without overflow pushes nothing
    xin(5'd0, 5'd0, 1'b1);
    cyc();
    idle();
    chk("add_valid", 32'(status_valid), 32'd1);
    chk("add_code", status_code, 32'd1);
    wb_grant = 1;
    cyc();
    idle();
    chk("add_pop_empty", 32'(status_valid), 32'd0);
    chk("add_pop_sticky", sticky_status, 32'h2);
    xin(5'd0, 5'd0, 1'b0);
    cyc();
    idle();
    chk("add_noovf", 32'(status_valid), 32'd0);

    // div exception and addi overflow in the same cycle: 5 before 2
    xin(5'd0, 5'd7, 1'b0);
    cyc();
    idle();
    repeat (5) cyc();
    md_ready     = 1;
    md_exception = 1;
    xin(5'd5, 5'd0, 1'b1);
    cyc();
    idle();
    chk("div_first", status_code, 32'd5);
    wb_grant = 1;
    cyc();
    chk("addi_second", status_code, 32'd2);
    cyc();
    idle();
    chk("divaddi_drained", 32'(status_valid), 32'd0);
    chk("divaddi_sticky", sticky_status, 32'h26);
    sticky_clear = 1;
    cyc();
    idle();
    chk("clear_sticky", sticky_status, 32'd0);

    // occupancy and stall_req, including push+pop at count 3 and at full
    xin(5'd0, 5'd1, 1'b1);
    cyc();
    chk("sub1_stall", 32'(stall_req), 32'd0);
    cyc();
    chk("sub2_stall", 32'(stall_req), 32'd0);
    cyc();
    chk("sub3_stall", 32'(stall_req), 32'd1);
    wb_grant = 1;
    cyc();
    chk("pushpop3_stall", 32'(stall_req), 32'd1);
    chk("pushpop3_code", status_code, 32'd3);
    wb_grant = 0;
    cyc();
    chk("full_stall", 32'(stall_req), 32'd1);
    wb_grant = 1;
    cyc();
    idle();
    chk("pushpop_full_valid", 32'(status_valid), 32'd1);
    wb_grant = 1;
    repeat (3) cyc();
    chk("drain3_valid", 32'(status_valid), 32'd1);
    chk("drain3_stall", 32'(stall_req), 32'd0);
    cyc();
    idle();
    chk("drain_empty", 32'(status_valid), 32'd0);
    chk("sub_sticky", sticky_status, 32'h8);
    sticky_clear = 1;
    cyc();
    idle();

    // flush wins over completion; ready while idle ignored; double issue flags proto_err
    xin(5'd0, 5'd6, 1'b0);
    cyc();
    idle();
    cyc();
    flush        = 1;
    md_ready     = 1;
    md_exception = 1;
    cyc();
    idle();
    chk("flush_nopush", 32'(status_valid), 32'd0);
    md_ready     = 1;
    md_exception = 1;
    cyc();
    idle();
    chk("idle_ready_ignored", 32'(status_valid), 32'd0);
    xin(5'd0, 5'd6, 1'b0);
    cyc();
    chk("proto_before", 32'(proto_err), 32'd0);
    xin(5'd0, 5'd7, 1'b0);
    cyc();
    idle();
    chk("proto_set", 32'(proto_err), 32'd1);
    md_ready     = 1;
    md_exception = 1;
    cyc();
    idle();
    chk("mult_kind_kept", status_code, 32'd4);
    wb_grant = 1;
    cyc();
    idle();
    chk("mult_sticky", sticky_status, 32'h10);
    sticky_clear = 1;
    cyc();
    idle();

    // sticky: pop 1 and 4 -> 0x12, then clear coinciding with pop of 3 -> 0x8
    xin(5'd0, 5'd0, 1'b1);
    cyc();
    xin(5'd0, 5'd6, 1'b0);
    cyc();
    md_ready     = 1;
    md_exception = 1;
    xin(5'd0, 5'd1, 1'b1);
    cyc();
    idle();
    chk("seq_head1", status_code, 32'd1);
    wb_grant = 1;
    cyc();
    chk("seq_head4", status_code, 32'd4);
    cyc();
    chk("seq_sticky12", sticky_status, 32'h12);
    chk("seq_head3", status_code, 32'd3);
    sticky_clear = 1;
    cyc();
    idle();
    chk("seq_sticky8", sticky_status, 32'h8);
    chk("seq_empty", 32'(status_valid), 32'd0);

    // reset with three entries queued
    xin(5'd0, 5'd0, 1'b1);
    cyc();
    xin(5'd5, 5'd0, 1'b1);
    cyc();
    xin(5'd0, 5'd1, 1'b1);
    cyc();
    idle();
    chk("pre_rst_stall", 32'(stall_req), 32'd1);
    reset = 1;
    cyc();
    reset = 0;
    chk("midrst_valid", 32'(status_valid), 32'd0);
    chk("midrst_code", status_code, 32'd0);
    chk("midrst_sticky", sticky_status, 32'd0);
    chk("midrst_proto", 32'(proto_err), 32'd0);
    xin(5'd5, 5'd0, 1'b1);
    cyc();
    idle();
    chk("post_rst_addi", status_code, 32'd2);
    cyc();
    @(negedge clock);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
